// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode/funct values, datapath select codes and decoder class indices.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  // Bit positions in the decoder's one-hot class vector.
  localparam int NCLS     = 11;
  localparam int CLS_ADDU = 0;
  localparam int CLS_SUBU = 1;
  localparam int CLS_NOP  = 2;
  localparam int CLS_JR   = 3;
  localparam int CLS_ORI  = 4;
  localparam int CLS_LUI  = 5;
  localparam int CLS_LW   = 6;
  localparam int CLS_SW   = 7;
  localparam int CLS_BEQ  = 8;
  localparam int CLS_J    = 9;
  localparam int CLS_JAL  = 10;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: opcode/funct to a one-hot class
// vector; anything outside the supported set leaves every bit clear.
module mc_decoder
  import mc_pkg::*;
(
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [NCLS-1:0] cls,
  output logic            legal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[CLS_ADDU] = 1'b1;
          FN_SUBU: cls[CLS_SUBU] = 1'b1;
          FN_NOP:  cls[CLS_NOP]  = 1'b1;
          FN_JR:   cls[CLS_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls[CLS_ORI] = 1'b1;
      OP_LUI:  cls[CLS_LUI] = 1'b1;
      OP_LW:   cls[CLS_LW]  = 1'b1;
      OP_SW:   cls[CLS_SW]  = 1'b1;
      OP_BEQ:  cls[CLS_BEQ] = 1'b1;
      OP_J:    cls[CLS_J]   = 1'b1;
      OP_JAL:  cls[CLS_JAL] = 1'b1;
      default: ;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer with shared-bus handshake, bus timeout and trap.
// Define MC_INSTRET_EN to build the retired-instruction counter on instret.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_is_data,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic [2:0]  state,
  output logic        trap,
  output logic        bus_err,
  output logic [31:0] instret
);

  state_t            r_state, w_next;
  logic [31:0]       r_cnt;
  logic              r_trap, r_bus_err;
  logic [NCLS-1:0]   w_cls;
  logic              w_legal, w_limit, w_stall;
  logic [2:0]        w_arith_op;
  logic              w_arith_srcb;

  mc_decoder u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (w_cls),
    .legal  (w_legal)
  );

  // r_cnt holds the stall cycles already spent, so the limit fires on the
  // BUS_TIMEOUT-th unacknowledged request cycle.
  assign w_limit = (BUS_TIMEOUT != 0) && (r_cnt == BUS_TIMEOUT - 1);
  assign w_stall = bus_req && !bus_ack;

  always_comb begin
    w_arith_op   = ALU_ADD;
    w_arith_srcb = 1'b0;
    if (w_cls[CLS_SUBU]) begin
      w_arith_op = ALU_SUB;
    end else if (w_cls[CLS_ORI]) begin
      w_arith_op   = ALU_OR;
      w_arith_srcb = 1'b1;
    end else if (w_cls[CLS_LUI]) begin
      w_arith_op   = ALU_LUI;
      w_arith_srcb = 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_is_data = 1'b0;
    pc_we       = 1'b0;
    npc_sel     = NPC_PC4;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = DST_RT;
    wd_sel      = WD_ALU;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    ext_op      = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_limit) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_HALT;
        end else if (w_cls[CLS_J]) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
          w_next  = S_FETCH;
        end else if (w_cls[CLS_JR]) begin
          pc_we   = 1'b1;
          npc_sel = NPC_RS;
          w_next  = S_FETCH;
        end else if (w_cls[CLS_JAL]) begin
          w_next = S_WB;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls[CLS_BEQ]) begin
          alu_op = ALU_SUB;
          if (alu_zero) begin
            pc_we   = 1'b1;
            npc_sel = NPC_BRANCH;
          end
          w_next = S_FETCH;
        end else if (w_cls[CLS_LW] || w_cls[CLS_SW]) begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          ext_op    = 1'b1;
          w_next    = S_MEM;
        end else if (w_cls[CLS_NOP]) begin
          w_next = S_FETCH;
        end else begin
          alu_op    = w_arith_op;
          alu_src_b = w_arith_srcb;
          w_next    = S_WB;
        end
      end
      S_MEM: begin
        bus_req     = 1'b1;
        bus_is_data = 1'b1;
        bus_we      = w_cls[CLS_SW];
        alu_op      = ALU_ADD;
        alu_src_b   = 1'b1;
        ext_op      = 1'b1;
        if (bus_ack) begin
          w_next = w_cls[CLS_SW] ? S_FETCH : S_WB;
        end else if (w_limit) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
        if (w_cls[CLS_JAL]) begin
          reg_dst = DST_RA;
          wd_sel  = WD_LINK;
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
        end else if (w_cls[CLS_LW]) begin
          wd_sel = WD_MEM;
        end else begin
          alu_op    = w_arith_op;
          alu_src_b = w_arith_srcb;
          if (w_cls[CLS_ADDU] || w_cls[CLS_SUBU]) reg_dst = DST_RD;
        end
      end
      S_HALT: ;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_trap    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_stall ? r_cnt + 32'd1 : '0;
      if (r_state == S_DECODE && !w_legal) r_trap <= 1'b1;
      if (w_stall && w_limit) r_bus_err <= 1'b1;
    end
  end

  assign state   = r_state;
  assign trap    = r_trap;
  assign bus_err = r_bus_err;

`ifdef MC_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instret <= '0;
    end else if (w_next == S_FETCH &&
                 (r_state == S_DECODE || r_state == S_EXEC ||
                  r_state == S_MEM    || r_state == S_WB)) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath (PC, IR, GRF, EXT, ALU, shared IM/DM bus).
- Replaces single-cycle combinational control: walks each instruction through FETCH/DECODE/EXEC/MEM/WB and emits per-state write strobes and mux selects.
- Owns the req/ack handshake to a single shared memory bus.
- Traps on illegal instructions and on bus timeout.

Parameters:
- BUS_TIMEOUT, 255, max cycles bus_req may wait for bus_ack; 0 = never time out.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU equal flag, sampled in EXEC.
- bus_ack  in  1  memory completes the current transfer this cycle.
- bus_req  out  1  memory transfer request.
- bus_we  out  1  write transfer (sw).
- bus_is_data  out  1  0 = instruction fetch address (PC), 1 = data address (ALU result).
- pc_we  out  1  PC load strobe.
- npc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- ir_we  out  1  IR load strobe.
- reg_we  out  1  GRF write strobe.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- wd_sel  out  2  0 = ALU result, 1 = memory data, 2 = link PC.
- alu_src_b  out  1  0 = rt, 1 = extended immediate.
- alu_op  out  3  0 = add, 1 = sub, 2 = or, 3 = lui (B<<16).
- ext_op  out  1  0 = zero-extend, 1 = sign-extend.
- state  out  3  current state, for debug.
- trap  out  1  illegal instruction seen.
- bus_err  out  1  bus timeout seen.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- While reset is low: state=IDLE; every output 0; timeout counter 0.
- IDLE: all strobes 0; next state FETCH unconditionally.
- FETCH: bus_req=1, bus_is_data=0.
  - On bus_ack: ir_we=1, pc_we=1 with npc_sel=0, same cycle; next state DECODE.
  - Without bus_ack: stay in FETCH.
- DECODE: classify opcode/funct.
  - j: pc_we=1, npc_sel=2; next FETCH.
  - jal: next WB.
  - jr: pc_we=1, npc_sel=3; next FETCH.
  - Other legal instructions: next EXEC.
  - Illegal: next HALT.
- Legal set: addu, subu, jr (opcode 0); ori, lui, lw, sw, beq, j, jal. Funct 0 with opcode 0 (nop/sll 0) is legal and retires after EXEC.
- EXEC: ALU controls driven per instruction.
  - beq: alu_op=sub; if alu_zero then pc_we=1, npc_sel=1; next FETCH.
  - lw/sw: alu_op=add, alu_src_b=1, ext_op=1; next MEM.
  - R-type and ori/lui: next WB.
- MEM: bus_req=1, bus_is_data=1, bus_we=1 only for sw; ALU controls held from EXEC.
  - On bus_ack: sw goes to FETCH; lw goes to WB.
- WB: reg_we=1, single cycle; next FETCH.
  - addu/subu: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0, alu_src_b=1, ext_op=0.
  - lw: reg_dst=0, wd_sel=1.
  - jal: reg_dst=2, wd_sel=2, plus pc_we=1, npc_sel=2.
- Cycle counts with zero-wait ack: j/jr 2; beq 3; sw, R-type, ori, lui 4; jal 3; lw 5.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle bus_req=1 without bus_ack.
  - When it reaches BUS_TIMEOUT (BUS_TIMEOUT≠0): bus_err=1, next HALT.
  - bus_ack arriving in the same cycle as the limit wins: transfer completes, no error.
- HALT: all strobes 0; trap/bus_err stay sticky; leaves HALT only on reset.
- Reset asserted mid-transfer: bus_req drops immediately (asynchronously); no partial strobe escapes.
- Control outputs are combinational from state, opcode, funct, alu_zero and bus_ack. trap and bus_err are registered.

Optional Feature:
- Macro: MC_INSTRET_EN.
- Defined: instret is a 32-bit counter that resets to 0 and increments by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB. It wraps 0xFFFFFFFF→0 and freezes in HALT.
- Undefined: instret is tied to 0 and no counter is built.

Decomposition:
- mc_pkg holds: state encodings; opcode/funct constants; ALU_OP, NPC_SEL, REG_DST and WD_SEL codes.
- Sub-module mc_decoder: combinational opcode/funct → one-hot instruction class plus legal flag. mc_controller holds the FSM, timeout counter and instret.

Test Plan:
- addu $3,$1,$2 with bus_ack tied high → IDLE,FETCH,DECODE,EXEC,WB; reg_we=1 with reg_dst=1 exactly in cycle 4 after IDLE; instret=1.
- lw with bus_ack delayed 3 cycles in both FETCH and MEM → bus_req held high 4 cycles each time; reg_we with wd_sel=1 in WB; 11 cycles total.
- beq with alu_zero=1, then again with alu_zero=0 → pc_we+npc_sel=1 only in the taken case; both return to FETCH after EXEC.
- opcode 0x3F → HALT after DECODE; trap=1 stays high 20 cycles with no strobes.
- BUS_TIMEOUT=4, bus_ack held low in FETCH → bus_err=1 and HALT after 4 req cycles; with ack arriving on cycle 4 → no error.
- Assert reset in MEM of sw with bus_ack low → bus_we/bus_req drop the same cycle; after release, state goes IDLE then FETCH; instret=0.
